// File: rtl/alu_mdu.sv
// Registered ALU with an iterative shift-add multiplier and restoring divider.
// Single-cycle ops finish the cycle after start; mul/divu/remu take WIDTH iterations.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             divzero_o
);

    // Handshake: start_i is accepted on a rising edge whenever busy_o is low
    // (IDLE or DONE); done_o pulses for one cycle when data_o is updated.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REMU = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;    // multiplicand (mul) or dividend/quotient shift register (div)
    logic [WIDTH-1:0] b_q;    // multiplier (mul) or divisor (div)
    logic [WIDTH-1:0] acc_q;  // product accumulator (mul) or partial remainder (div)
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] alu_res;
    logic             is_iter;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_ADD:  alu_res = data1_i + data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: alu_res = '0;
        endcase
        is_iter = (ALUCtrl_i == OP_MUL) || (ALUCtrl_i == OP_DIVU) || (ALUCtrl_i == OP_REMU);
    end

    // One iteration of each engine; a zero divisor falls out naturally as
    // an all-ones quotient with the dividend left as the remainder.
    always_comb begin
        mul_acc_next = b_q[0] ? (acc_q + a_q) : acc_q;
        div_tmp      = {acc_q, a_q[WIDTH-1]};
        div_diff     = div_tmp - {1'b0, b_q};
        div_ge       = (div_tmp >= {1'b0, b_q});
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
        div_quo_next = {a_q[WIDTH-2:0], div_ge};
        iter_res     = div_rem_next;
        if (op_q == OP_MUL) begin
            iter_res = mul_acc_next;
        end else if (op_q == OP_DIVU) begin
            iter_res = div_quo_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            data_o    <= '0;
            Zero_o    <= 1'b1;
            divzero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (is_iter) begin
                            op_q   <= ALUCtrl_i;
                            a_q    <= data1_i;
                            b_q    <= data2_i;
                            acc_q  <= '0;
                            cnt_q  <= CW'(WIDTH);
                            busy_o <= 1'b1;
                            state  <= CALC;
                        end else begin
                            data_o    <= alu_res;
                            Zero_o    <= (alu_res == '0);
                            divzero_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_acc_next;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        acc_q <= div_rem_next;
                        a_q   <= div_quo_next;
                    end
                    if (cnt_q == CW'(1)) begin
                        data_o    <= iter_res;
                        Zero_o    <= (iter_res == '0);
                        divzero_o <= (op_q != OP_MUL) && (b_q == '0);
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: table vectors, random ops against an arithmetic model,
// and hand-written protocol/reset sequences on WIDTH=32 and WIDTH=8 instances.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] d1 = '0, d2 = '0;
    logic        busy, done, zero, divz;
    logic [31:0] data;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, zero8, divz8;
    logic [7:0]  data8;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last32 = '0;
    logic [7:0]  last8 = '0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(op),
        .data1_i(d1), .data2_i(d2), .busy_o(busy), .done_o(done),
        .data_o(data), .Zero_o(zero), .divzero_o(divz)
    );

    alu_mdu #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .ALUCtrl_i(op8),
        .data1_i(a8), .data2_i(b8), .busy_o(busy8), .done_o(done8),
        .data_o(data8), .Zero_o(zero8), .divzero_o(divz8)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        dz;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_iter(input logic [2:0] o);
        return (o == 3'd4) || (o == 3'd5) || (o == 3'd6);
    endfunction

    // Reference arithmetic for a w-bit unit, computed on 64-bit integers.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input int w);
        longint unsigned mask, ua, ub, r;
        longint sa, sb;
        mask = (64'd1 << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = ua[w-1] ? longint'(ua) - (64'sd1 <<< w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - (64'sd1 <<< w) : longint'(ub);
        case (o)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ua + ub;
            3'd3: r = ua - ub;
            3'd4: r = ua * ub;
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : ua % ub;
            default: r = (sa < sb) ? 64'd1 : 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    task automatic issue32(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_d,
                           input logic exp_z, input logic exp_dz);
        int cyc, busy_n, hold_bad, exp_lat;
        exp_lat = is_iter(o) ? 33 : 1;
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); d1 = $urandom; d2 = $urandom;
        cyc = 1; busy_n = 0; hold_bad = 0;
        while (!done && cyc <= 80) begin
            if (busy) busy_n++;
            if (data !== last32) hold_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " data"}, 64'(data), 64'(exp_d));
        check({name, " zero"}, 64'(zero), 64'(exp_z));
        check({name, " divzero"}, 64'(divz), 64'(exp_dz));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        check({name, " data_hold"}, 64'(hold_bad), 64'd0);
        last32 = exp_d;
        @(posedge clk); #1;
        check({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic issue8(input string name, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_d,
                          input logic exp_z, input logic exp_dz);
        int cyc, busy_n, exp_lat;
        exp_lat = is_iter(o) ? 9 : 1;
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1; busy_n = 0;
        while (!done8 && cyc <= 40) begin
            if (busy8) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " data"}, 64'(data8), 64'(exp_d));
        check({name, " zero"}, 64'(zero8), 64'(exp_z));
        check({name, " divzero"}, 64'(divz8), 64'(exp_dz));
        check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        last8 = exp_d;
    endtask

    initial begin
        int cyc, dones, first_done;
        logic [31:0] got, ra, rb, rexp;
        logic [7:0]  ra8, rb8, rexp8;
        logic [2:0]  rop;

        tbl[0]  = '{"add_wrap",  3'd2, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
        tbl[1]  = '{"sub_neg",   3'd3, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2]  = '{"mul_7x6",   3'd4, 32'd7,        32'd6,        32'd42,       1'b0, 1'b0};
        tbl[3]  = '{"mul_wrap",  3'd4, 32'h10000,    32'h10000,    32'h0,        1'b1, 1'b0};
        tbl[4]  = '{"divu_100",  3'd5, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0};
        tbl[5]  = '{"remu_100",  3'd6, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0};
        tbl[6]  = '{"divu_by0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[7]  = '{"remu_by0",  3'd6, 32'd5,        32'd0,        32'd5,        1'b0, 1'b1};
        tbl[8]  = '{"and_clrdz", 3'd0, 32'd3,        32'd1,        32'd1,        1'b0, 1'b0};
        tbl[9]  = '{"slt_neg",   3'd7, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        tbl[10] = '{"slt_pos",   3'd7, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
        tbl[11] = '{"or_f0_0f",  3'd1, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0};
        tbl[12] = '{"slt_min",   3'd7, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};

        // Clock/reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst data", 64'(data), 64'd0);
        check("rst zero", 64'(zero), 64'd1);
        check("rst divzero", 64'(divz), 64'd0);
        check("rst8 data", 64'(data8), 64'd0);
        check("rst8 zero", 64'(zero8), 64'd1);

        // WIDTH=8 corner cases and random
        issue8("w8_mul_ff", 3'd4, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0);
        issue8("w8_divu",   3'd5, 8'hFF, 8'h10, 8'h0F, 1'b0, 1'b0);
        issue8("w8_remu",   3'd6, 8'hFF, 8'h10, 8'h0F, 1'b0, 1'b0);
        issue8("w8_div0",   3'd5, 8'h07, 8'h00, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra8 = 8'($urandom);
            rb8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            rexp8 = 8'(ref_model(rop, 32'(ra8), 32'(rb8), 8));
            issue8("w8_rand", rop, ra8, rb8, rexp8, rexp8 == 8'h0,
                   ((rop == 3'd5) || (rop == 3'd6)) && (rb8 == 8'h0));
        end

        // WIDTH=32 table
        for (int i = 0; i < 13; i++) begin
            issue32(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z, tbl[i].dz);
        end

        // start pulses while a mul is busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd4; d1 = 32'd7; d2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; dones = 0; first_done = 0; got = '0;
        while (cyc <= 75) begin
            if (done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = cyc;
                    got = data;
                end
            end
            start = (cyc == 5) || (cyc == 12) || (cyc == 20);
            op = (cyc == 12) ? 3'd2 : 3'd4;
            d1 = 32'd9; d2 = 32'd11;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("busy_start dones", 64'(dones), 64'd1);
        check("busy_start latency", 64'(first_done), 64'd33);
        check("busy_start data", 64'(got), 64'd42);
        last32 = 32'd42;

        // slt issued in the DONE cycle of an and
        @(negedge clk);
        start = 1'b1; op = 3'd0; d1 = 32'd6; d2 = 32'd3;
        @(posedge clk); #1;
        check("b2b and done", 64'(done), 64'd1);
        check("b2b and data", 64'(data), 64'd2);
        op = 3'd7; d1 = 32'hFFFFFFFF; d2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b slt done", 64'(done), 64'd1);
        check("b2b slt data", 64'(data), 64'd1);
        @(posedge clk); #1;
        check("b2b idle done", 64'(done), 64'd0);
        last32 = 32'd1;

        // reset in cycle 10 of a divu abandons it
        issue32("pre_rst_and", 3'd0, 32'hFF, 32'hF0, 32'hF0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; d1 = 32'd1000; d2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort data", 64'(data), 64'd0);
        check("abort zero", 64'(zero), 64'd1);
        check("abort done", 64'(done), 64'd0);
        last32 = '0;
        last8 = '0;
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("abort no_done", 64'(dones), 64'd0);
        issue32("post_rst_or", 3'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);

        // WIDTH=32 random against the model
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rexp = ref_model(rop, ra, rb, 32);
            issue32("rand", rop, ra, rb, rexp, rexp == 32'd0,
                    ((rop == 3'd5) || (rop == 3'd6)) && (rb == 32'd0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // done and busy must never be high together on either instance
    always @(negedge clk) begin
        if (!rst && ((done && busy) || (done8 && busy8))) begin
            n_vec++;
            n_err++;
            $display("FAIL done_busy_overlap: got done=%0b busy=%0b done8=%0b busy8=%0b expected no overlap",
                     done, busy, done8, busy8);
        end
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the datapath ALU: a registered ALU with an iterative shift-add multiplier and restoring divider behind a start/done handshake. Sits in the EX stage (or a multi-cycle execute unit). Single-cycle ops complete the cycle after start. Multiply/divide/remainder take WIDTH iteration cycles, and the pipeline stalls on busy_o.

## Interface
- WIDTH, 32: operand/result width in bits (≥ 4).
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only when busy_o = 0.
- ALUCtrl_i  in  3  operation, sampled with start_i.
- data1_i  in  WIDTH  operand A, sampled with start_i.
- data2_i  in  WIDTH  operand B, sampled with start_i.
- busy_o  out  1  iterative operation in progress.
- done_o  out  1  one-cycle pulse; data_o/Zero_o/divzero_o valid and updated.
- data_o  out  WIDTH  result register; holds until the next done_o.
- Zero_o  out  1  (data_o == 0); tracks the data_o register.
- divzero_o  out  1  last completed divu/remu had data2 = 0; cleared by any other completion.

## Operation
- ALUCtrl_i encoding:
  - 000 and.
  - 001 or.
  - 010 add.
  - 011 sub.
  - 100 mul: low WIDTH bits of the unsigned product.
  - 101 divu: unsigned quotient.
  - 110 remu: unsigned remainder.
  - 111 slt: signed A < B gives 1, else 0.
- Add, sub and mul wrap modulo 2^WIDTH.
- FSM states IDLE, CALC, DONE:
  - IDLE, start_i=1, op 000/001/010/011/111: result written to data_o, done_o=1 next cycle, go to DONE.
  - IDLE, start_i=1, op 100/101/110: latch operands, iteration counter = WIDTH, busy_o=1, go to CALC.
  - CALC: one iteration per cycle, counter decrements. The cycle that executes the last iteration writes data_o and asserts done_o, then goes to DONE.
  - DONE: done_o=1 for exactly this cycle, busy_o=0. A start_i in DONE is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Operands and opcode are latched at acceptance. Input changes while busy are ignored.
- start_i while busy_o=1 is ignored. It is not queued and produces no extra done_o.
- Multiply: shift-add over the latched operands, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle.
- Divide by zero needs no special path:
  - quotient = all ones;
  - remainder = data1;
  - divzero_o = 1;
  - normal latency.
- Reset values: state IDLE, data_o=0, Zero_o=1, busy_o=0, done_o=0, divzero_o=0, counter=0.
- rst_i asserted mid-operation:
  - abandons the operation;
  - all outputs take reset values on the next edge;
  - no done_o is produced for the aborted request.

## Timing
- Start accepted at edge 0.
- Single-cycle ops: done_o high in cycle 1 (latency 1).
- Iterative ops:
  - busy_o high in cycles 1..WIDTH;
  - done_o high in cycle WIDTH+1, with busy_o already low (latency WIDTH+1).
- Throughput:
  - one single-cycle op per cycle when start_i is held high across DONE;
  - one iterative op per WIDTH+1 cycles.
- data_o, Zero_o and divzero_o change only in a done_o cycle or on reset.
- done_o and busy_o are never high in the same cycle.

## Test plan
- WIDTH=32: add 0xFFFFFFFF + 0x00000001 → done_o in cycle 1, data_o=0, Zero_o=1. Then sub 5 − 7 → 0xFFFFFFFE, Zero_o=0.
- WIDTH=32: mul 7 × 6 → busy_o high cycles 1..32, done_o at cycle 33, data_o=42. Then mul 0x10000 × 0x10000 → data_o=0, Zero_o=1.
- WIDTH=32, divide:
  - divu 100/7 → 14;
  - remu 100/7 → 2;
  - divu 5/0 → 0xFFFFFFFF, divzero_o=1;
  - remu 5/0 → 5, divzero_o=1;
  - following and 3 & 1 → 1, divzero_o=0.
- Protocol:
  - start_i pulses during a mul, with different operands → ignored, single done_o with the original result;
  - slt issued in the DONE cycle → accepted, done_o next cycle;
  - slt 0xFFFFFFFF vs 1 → 1.
- Reset: rst_i asserted in cycle 10 of a divu → next cycle busy_o=0, data_o=0, Zero_o=1; no done_o for 40 cycles; subsequent or 0xF0 | 0x0F → 0xFF.
- WIDTH=8: mul 0xFF × 0xFF → 0x01 with done_o at cycle 9; divu 0xFF/0x10 → 0x0F; remu → 0x0F.
